// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit (package pipe_pkg).
// rd is stored at RW_MAX bits so one entry type serves every legal RW.
package pipe_pkg;
  localparam int RW_DEFAULT  = 5;
  localparam int RW_MAX      = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic              load;
    logic [RW_MAX-1:0] rd;
  } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request and hazard/forwarding response bundle.
// master = decode stage, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int DEPTH = 3,
  parameter int RW    = pipe_pkg::RW_DEFAULT
);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wreg;
  logic          id_m2reg;
  logic [RW-1:0] id_rd;
  logic          flush;
  logic          ext_stall;
  logic          stall;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic [CW-1:0] inflight_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rd,
    output flush, ext_stall,
    input  stall, fwd_a, fwd_b, inflight_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rd,
    input  flush, ext_stall,
    output stall, fwd_a, fwd_b, inflight_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit_match_prio.sv
// Youngest-producer search over scoreboard entries 1..N for one source operand.
module pipe_match_prio
  import pipe_pkg::*;
#(
  parameter int N  = 2,
  parameter int RW = RW_DEFAULT,
  parameter int FW = 2
) (
  input  logic          use_src,
  input  logic [RW-1:0] src,
  input  sb_entry_t [N:1] ent,
  output logic          hit,
  output logic [FW-1:0] idx,
  output logic          load
);
  // Scan oldest to youngest so the smallest matching index overwrites the rest.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    load = 1'b0;
    if (use_src && (src != '0)) begin
      for (int k = N; k >= 1; k--) begin
        if (ent[k].valid && (ent[k].rd == RW_MAX'(src))) begin
          hit  = 1'b1;
          idx  = FW'(k);
          load = ent[k].load;
        end
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard detection and operand forwarding for the in-order pipeline.
// Define PIPE_FWD_EN for forwarding; otherwise every in-flight RAW hazard stalls.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int RW         = RW_DEFAULT,
  parameter int LOAD_STAGE = 2
) (
  input logic              clock,
  input logic              reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH:1] sb;
  sb_entry_t           new_entry;
  logic                hit_a, hit_b, ld_a, ld_b, haz_a, haz_b, stall_int;
  logic [FW-1:0]       idx_a, idx_b;
  logic [CW-1:0]       cnt;

  pipe_match_prio #(.N(DEPTH - 1), .RW(RW), .FW(FW)) u_match_rs (
    .use_src (hz.id_use_rs),
    .src     (hz.id_rs),
    .ent     (sb[DEPTH-1:1]),
    .hit     (hit_a),
    .idx     (idx_a),
    .load    (ld_a)
  );

  pipe_match_prio #(.N(DEPTH - 1), .RW(RW), .FW(FW)) u_match_rt (
    .use_src (hz.id_use_rt),
    .src     (hz.id_rt),
    .ent     (sb[DEPTH-1:1]),
    .hit     (hit_b),
    .idx     (idx_b),
    .load    (ld_b)
  );

`ifdef PIPE_FWD_EN
  // A load still short of LOAD_STAGE has no data yet: interlock instead of forwarding.
  assign haz_a    = hit_a && ld_a && (int'(idx_a) < LOAD_STAGE);
  assign haz_b    = hit_b && ld_b && (int'(idx_b) < LOAD_STAGE);
  assign hz.fwd_a = (hit_a && !haz_a) ? idx_a : FW'(FWD_REGFILE);
  assign hz.fwd_b = (hit_b && !haz_b) ? idx_b : FW'(FWD_REGFILE);
`else
  logic unused_nofwd;
  assign haz_a        = hit_a;
  assign haz_b        = hit_b;
  assign hz.fwd_a     = FW'(FWD_REGFILE);
  assign hz.fwd_b     = FW'(FWD_REGFILE);
  assign unused_nofwd = ^{ld_a, ld_b, idx_a, idx_b, (LOAD_STAGE > 0)};
`endif

  assign stall_int = (haz_a || haz_b) && hz.id_valid && !hz.flush;
  assign hz.stall  = stall_int;

  always_comb begin
    new_entry = '0;
    if (hz.id_valid && !hz.flush && !stall_int) begin
      new_entry.valid = hz.id_wreg && (hz.id_rd != '0);
      new_entry.load  = hz.id_m2reg;
      new_entry.rd    = RW_MAX'(hz.id_rd);
    end
  end

  // Scoreboard: entry k is the instruction k stages past ID; only valid bits are reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) sb[k].valid <= 1'b0;
    end else if (!hz.ext_stall) begin
      sb[1] <= new_entry;
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 1; k <= DEPTH; k++) cnt = cnt + CW'(sb[k].valid);
  end
  assign hz.inflight_cnt = cnt;

  // The retiring stage is covered by register-file write-through; only its valid bit is read.
  logic unused_tail;
  assign unused_tail = ^{sb[DEPTH].load, sb[DEPTH].rd};
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, hand sequences, random vs. history model.
// Expectations follow whether PIPE_FWD_EN is defined for the build.
module tb_pipe_hazard_unit;
  import pipe_pkg::*;

  localparam int DEPTH      = 3;
  localparam int RW         = 5;
  localparam int LOAD_STAGE = 2;
`ifdef PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.DEPTH(DEPTH), .RW(RW)) hz ();

  pipe_hazard_unit #(.DEPTH(DEPTH), .RW(RW), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clock (clk),
    .reset (rst),
    .hz    (hz)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int v, rs, rt, urs, urt, wreg, ld, rd, fl, xs, rs_in;
    int st_f, fa_f, fb_f, cnt_f;  // expected with forwarding
    int st_n, cnt_n;              // expected without forwarding (fwd always 0)
  } vec_t;

  typedef struct { bit wr; int rd; bit ld; } ins_t;
  ins_t hist [1:DEPTH];  // hist[a] = instruction issued a cycles ago

  vec_t tbl[$];
  vec_t hand[$];

  function automatic vec_t r(int v, int rs, int rt, int urs, int urt, int wreg, int ld, int rd,
                             int fl, int xs, int rs_in, int st_f, int fa_f, int fb_f, int cnt_f,
                             int st_n, int cnt_n);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.wreg = wreg; t.ld = ld;
    t.rd = rd; t.fl = fl; t.xs = xs; t.rs_in = rs_in; t.st_f = st_f; t.fa_f = fa_f;
    t.fb_f = fb_f; t.cnt_f = cnt_f; t.st_n = st_n; t.cnt_n = cnt_n;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rs_in[0];
    hz.id_valid  = v.v[0];
    hz.id_rs     = RW'(v.rs);
    hz.id_rt     = RW'(v.rt);
    hz.id_use_rs = v.urs[0];
    hz.id_use_rt = v.urt[0];
    hz.id_wreg   = v.wreg[0];
    hz.id_m2reg  = v.ld[0];
    hz.id_rd     = RW'(v.rd);
    hz.flush     = v.fl[0];
    hz.ext_stall = v.xs[0];
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(hz.stall), FWD_EN ? v.st_f : v.st_n);
    chk({tag, "_fwd_a"}, 32'(hz.fwd_a), FWD_EN ? v.fa_f : 0);
    chk({tag, "_fwd_b"}, 32'(hz.fwd_b), FWD_EN ? v.fb_f : 0);
    chk({tag, "_cnt"}, 32'(hz.inflight_cnt), FWD_EN ? v.cnt_f : v.cnt_n);
  endtask

  function automatic void m_eval(input bit use_src, input int src, output bit haz, output int fwd);
    haz = 1'b0;
    fwd = 0;
    if (!use_src || src == 0) return;
    for (int a = 1; a < DEPTH; a++) begin
      if (hist[a].wr && hist[a].rd == src) begin
        if (!FWD_EN) haz = 1'b1;
        else if (hist[a].ld && a < LOAD_STAGE) haz = 1'b1;
        else fwd = a;
        return;
      end
    end
  endfunction

  initial begin
    vec_t idle;
    idle = r(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0);
    drive(idle);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(hz.stall), 0);
    chk("reset_fwd_a", 32'(hz.fwd_a), 0);
    chk("reset_fwd_b", 32'(hz.fwd_b), 0);
    chk("reset_cnt", 32'(hz.inflight_cnt), 0);

    //              v rs rt urs urt wr ld rd  fl xs rst  st fa fb cnt  stN cntN
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 0, 3,  0, 0, 0,   0, 0, 0, 0,   0, 0));  // add r3
    tbl.push_back(r(1, 3, 0, 1, 0, 1, 0, 7,  0, 0, 0,   0, 1, 0, 1,   1, 1));  // sub reads r3
    tbl.push_back(r(1, 3, 0, 1, 0, 1, 0, 7,  0, 0, 0,   0, 2, 0, 2,   1, 1));
    tbl.push_back(r(1, 3, 0, 1, 0, 1, 0, 7,  0, 0, 0,   0, 0, 0, 3,   0, 1));
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0,   0, 0, 0, 3,   0, 1));  // write r0
    tbl.push_back(r(1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2,   0, 1));  // read r0
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 0, 4,  0, 0, 0,   0, 0, 0, 1,   0, 1));  // write r4
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 0, 4,  0, 0, 0,   0, 0, 0, 1,   0, 1));  // write r4
    tbl.push_back(r(1, 4, 0, 1, 0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 2,   1, 2));  // youngest wins
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 1, 5,  0, 0, 0,   0, 0, 0, 2,   0, 2));  // lw r5
    tbl.push_back(r(1, 0, 5, 0, 1, 1, 0, 6,  0, 0, 0,   1, 0, 0, 2,   1, 2));  // load-use
    tbl.push_back(r(1, 0, 5, 0, 1, 1, 0, 6,  0, 0, 0,   0, 0, 2, 1,   1, 1));
    tbl.push_back(r(1, 0, 0, 0, 0, 1, 1, 8,  0, 0, 0,   0, 0, 0, 2,   0, 1));  // lw r8
    tbl.push_back(r(1, 8, 0, 1, 0, 1, 0, 9,  1, 0, 0,   0, 0, 0, 2,   0, 1));  // hazard + flush
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 2,   0, 1));  // freeze
    tbl.push_back(r(1, 8, 0, 1, 0, 0, 0, 0,  0, 1, 0,   0, 2, 0, 2,   1, 1));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 2,   0, 1));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 2,   0, 1));  // reset
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Reset arriving during a load-use stall.
    hand.push_back(r(1, 0, 0, 0, 0, 1, 1, 5,  0, 0, 0,   0, 0, 0, 0,   0, 0));
    hand.push_back(r(1, 0, 5, 0, 1, 0, 0, 0,  0, 0, 1,   1, 0, 0, 1,   1, 1));
    hand.push_back(r(1, 0, 5, 0, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0));
    for (int i = 0; i < hand.size(); i++) apply(hand[i], $sformatf("rstmid%0d", i));

    // Scoreboard now holds no valid entries.
    for (int a = 1; a <= DEPTH; a++) hist[a] = '{1'b0, 0, 1'b0};

    for (int i = 0; i < 400; i++) begin
      vec_t v;
      bit ha, hb, mstall;
      int fa, fb, mcnt;
      v.v = ($urandom_range(0, 7) != 0); v.rs = $urandom_range(0, 5); v.rt = $urandom_range(0, 5);
      v.urs = $urandom_range(0, 1); v.urt = $urandom_range(0, 1); v.wreg = $urandom_range(0, 3) != 0;
      v.ld = $urandom_range(0, 2) == 0; v.rd = $urandom_range(0, 5);
      v.fl = $urandom_range(0, 7) == 0; v.xs = $urandom_range(0, 7) == 0;
      v.rs_in = $urandom_range(0, 49) == 0;
      @(posedge clk);
      #1;
      drive(v);
      m_eval(v.urs[0], v.rs, ha, fa);
      m_eval(v.urt[0], v.rt, hb, fb);
      mstall = (ha || hb) && v.v != 0 && v.fl == 0;
      mcnt = 0;
      for (int a = 1; a <= DEPTH; a++) mcnt += hist[a].wr;
      @(negedge clk);
      chk($sformatf("rnd%0d_stall", i), 32'(hz.stall), 32'(mstall));
      chk($sformatf("rnd%0d_fwd_a", i), 32'(hz.fwd_a), fa);
      chk($sformatf("rnd%0d_fwd_b", i), 32'(hz.fwd_b), fb);
      chk($sformatf("rnd%0d_cnt", i), 32'(hz.inflight_cnt), mcnt);
      if (v.rs_in != 0) begin
        for (int a = 1; a <= DEPTH; a++) hist[a].wr = 1'b0;
      end else if (v.xs == 0) begin
        for (int a = DEPTH; a >= 2; a--) hist[a] = hist[a-1];
        if (v.v != 0 && v.fl == 0 && !mstall)
          hist[1] = '{(v.wreg != 0 && v.rd != 0), v.rd, (v.ld != 0)};
        else
          hist[1] = '{1'b0, 0, 1'b0};
      end
    end

    @(posedge clk);
    #1;
    drive(idle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
